// File: rtl/udp_tx_arbiter.sv
// Round-robin packet arbiter in front of the UDP stack send port: whole-packet grants,
// length enforcement, start timeout. Optional channel-ID prefix byte: `define UDP_ARB_CHID_EN.
module udp_tx_arbiter #(
    parameter int unsigned P_CH       = 2,
    parameter int unsigned P_START_TO = 64,
    parameter int unsigned P_IFG      = 12
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [P_CH-1:0]      i_req,
    input  logic [16*P_CH-1:0]   i_req_len,
    input  logic [8*P_CH-1:0]    i_data,
    input  logic [P_CH-1:0]      i_valid,
    input  logic [P_CH-1:0]      i_last,
    output logic [P_CH-1:0]      o_grant,
    output logic [15:0]          o_send_len,
    output logic [7:0]           o_send_data,
    output logic                 o_send_last,
    output logic                 o_send_valid,
    input  logic                 i_send_ready,
    output logic                 o_len_err,
    output logic                 o_timeout,
    output logic                 o_busy
);

    localparam int unsigned CW = (P_CH > 1) ? $clog2(P_CH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_XFER, S_GAP} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   ptr, ptr_n, ch, ch_n, pick;
    logic [15:0]     len, len_n, cnt, cnt_n, tmr, tmr_n;
    logic            pad, pad_n;
    logic [P_CH-1:0] grant, grant_n;
    logic [7:0]      p_data, p_data_n;
    logic            p_valid, p_valid_n, p_last, p_last_n;
    logic            len_err, len_err_n, timeout, timeout_n;

    logic [15:0]     len_a  [P_CH];
    logic [7:0]      data_a [P_CH];
    logic [P_CH-1:0] elig;
    logic            found, emit, last_slot;
    logic            sel_valid, sel_last;
    logic [7:0]      sel_data;
    int unsigned     idx;

    always_comb begin
        for (int unsigned k = 0; k < P_CH; k++) begin
            len_a[k]  = i_req_len[16*k +: 16];
            data_a[k] = i_data[8*k +: 8];
`ifdef UDP_ARB_CHID_EN
            elig[k]   = i_req[k] && (len_a[k] != '0) && (len_a[k] != '1);
`else
            elig[k]   = i_req[k] && (len_a[k] != '0);
`endif
        end
    end

    assign sel_valid = i_valid[ch];
    assign sel_last  = i_last[ch];
    assign sel_data  = data_a[ch];

    // First eligible requester at or after the round-robin pointer.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int unsigned i = 0; i < P_CH; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= P_CH) idx = idx - P_CH;
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = CW'(idx);
            end
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        ch_n      = ch;
        len_n     = len;
        cnt_n     = cnt;
        tmr_n     = tmr;
        pad_n     = pad;
        grant_n   = grant;
        p_data_n  = '0;
        p_valid_n = 1'b0;
        p_last_n  = 1'b0;
        len_err_n = 1'b0;
        timeout_n = 1'b0;
        last_slot = (cnt == len - 16'd1);
        emit      = (state == S_XFER) || ((state == S_GRANT) && sel_valid);

        case (state)
            S_IDLE: begin
                if (i_send_ready && found) begin
                    ch_n          = pick;
                    len_n         = len_a[pick];
                    grant_n       = '0;
                    grant_n[pick] = 1'b1;
                    cnt_n         = '0;
                    tmr_n         = '0;
                    pad_n         = 1'b0;
                    state_n       = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!sel_valid) begin
                    if (tmr == 16'(P_START_TO - 1)) begin
                        grant_n   = '0;
                        timeout_n = 1'b1;
                        tmr_n     = '0;
                        state_n   = S_GAP;
                    end else begin
                        tmr_n = tmr + 16'd1;
                    end
                end
            end
            S_GAP: begin
                if (tmr == 16'(P_IFG - 1)) begin
                    ptr_n   = (ch == CW'(P_CH - 1)) ? '0 : ch + CW'(1);
                    state_n = S_IDLE;
                end else begin
                    tmr_n = tmr + 16'd1;
                end
            end
            default: ;
        endcase

        // One output slot per cycle once streaming starts; padding keeps the frame contiguous.
        if (emit) begin
            p_valid_n = 1'b1;
            if (pad) begin
                p_data_n = '0;
            end else if (!sel_valid) begin
                p_data_n  = '0;
                pad_n     = 1'b1;
                len_err_n = 1'b1;
                grant_n   = '0;
            end else begin
                p_data_n = sel_data;
                if (last_slot) begin
                    if (!sel_last) len_err_n = 1'b1;
                end else if (sel_last) begin
                    pad_n     = 1'b1;
                    len_err_n = 1'b1;
                    grant_n   = '0;
                end
            end
            if (last_slot) begin
                p_last_n = 1'b1;
                grant_n  = '0;
                tmr_n    = '0;
                state_n  = S_GAP;
            end else begin
                cnt_n   = cnt + 16'd1;
                state_n = S_XFER;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            ptr     <= '0;
            ch      <= '0;
            len     <= '0;
            cnt     <= '0;
            tmr     <= '0;
            pad     <= 1'b0;
            grant   <= '0;
            p_data  <= '0;
            p_valid <= 1'b0;
            p_last  <= 1'b0;
            len_err <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            ch      <= ch_n;
            len     <= len_n;
            cnt     <= cnt_n;
            tmr     <= tmr_n;
            pad     <= pad_n;
            grant   <= grant_n;
            p_data  <= p_data_n;
            p_valid <= p_valid_n;
            p_last  <= p_last_n;
            len_err <= len_err_n;
            timeout <= timeout_n;
        end
    end

`ifdef UDP_ARB_CHID_EN
    // The ID byte takes the slot of the first payload byte; payload trails by one register.
    logic [7:0] q_data;
    logic       q_valid, q_last, id_slot;

    assign id_slot = (state == S_GRANT) && sel_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            q_data  <= '0;
            q_valid <= 1'b0;
            q_last  <= 1'b0;
        end else if (id_slot) begin
            q_data  <= 8'(ch);
            q_valid <= 1'b1;
            q_last  <= 1'b0;
        end else begin
            q_data  <= p_data;
            q_valid <= p_valid;
            q_last  <= p_last;
        end
    end

    assign o_send_data  = q_data;
    assign o_send_valid = q_valid;
    assign o_send_last  = q_last;
    assign o_send_len   = !q_valid ? '0 : ((len == '1) ? '1 : len + 16'd1);
`else
    assign o_send_data  = p_data;
    assign o_send_valid = p_valid;
    assign o_send_last  = p_last;
    assign o_send_len   = p_valid ? len : '0;
`endif

    assign o_grant   = grant;
    assign o_len_err = len_err;
    assign o_timeout = timeout;
    assign o_busy    = (state != S_IDLE);

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Self-checking bench for udp_tx_arbiter: directed scenarios plus randomized packets
// compared against a frame/order reference model (honours UDP_ARB_CHID_EN).
module tb_udp_tx_arbiter;

    localparam int NCH      = 3;
    localparam int START_TO = 64;
    localparam int IFG      = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NCH-1:0]    i_req = '0;
    logic [16*NCH-1:0] i_req_len = '0;
    logic [8*NCH-1:0]  i_data = '0;
    logic [NCH-1:0]    i_valid = '0;
    logic [NCH-1:0]    i_last = '0;
    logic [NCH-1:0]    o_grant;
    logic [15:0]       o_send_len;
    logic [7:0]        o_send_data;
    logic              o_send_last, o_send_valid;
    logic              i_send_ready = 1'b1;
    logic              o_len_err, o_timeout, o_busy;

    udp_tx_arbiter #(.P_CH(NCH), .P_START_TO(START_TO), .P_IFG(IFG)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(i_req), .i_req_len(i_req_len),
        .i_data(i_data), .i_valid(i_valid), .i_last(i_last), .o_grant(o_grant),
        .o_send_len(o_send_len), .o_send_data(o_send_data), .o_send_last(o_send_last),
        .o_send_valid(o_send_valid), .i_send_ready(i_send_ready), .o_len_err(o_len_err),
        .o_timeout(o_timeout), .o_busy(o_busy));

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-channel packet plan: declared length, bytes presented, index carrying i_last (-1 none).
    int         p_len [NCH];
    int         p_nv  [NCH];
    int         p_la  [NCH];
    logic [7:0] p_d   [NCH][64];

    // Output monitor
    logic [7:0]  ob_q[$];
    bit          ol_q[$];
    logic [15:0] olen_q[$];
    int          go_q[$], gd_q[$], idle_q[$];
    int          frames_done = 0, errs = 0, tos = 0, gaps = 0, multi = 0, len_nz = 0;
    int          idle = 0, gdur = 0;
    bit          in_frame = 0, has_prev = 0;
    logic [NCH-1:0] prev_grant = '0;

    function automatic int gidx(input logic [NCH-1:0] g);
        int r = -1;
        for (int i = 0; i < NCH; i++) if (g[i] && r < 0) r = i;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame <= 0; has_prev <= 0; prev_grant <= '0; idle <= 0; gdur <= 0;
        end else begin
            if (o_send_valid) begin
                if (!in_frame && has_prev) idle_q.push_back(idle);
                ob_q.push_back(o_send_data);
                ol_q.push_back(o_send_last);
                olen_q.push_back(o_send_len);
                in_frame <= !o_send_last;
                if (o_send_last) begin
                    frames_done <= frames_done + 1;
                    has_prev <= 1;
                    idle <= 0;
                end
            end else begin
                if (in_frame) gaps <= gaps + 1;
                if (o_send_len != 0) len_nz <= len_nz + 1;
                idle <= idle + 1;
            end
            if (o_len_err) errs <= errs + 1;
            if (o_timeout) tos <= tos + 1;
            if (!$onehot0(o_grant)) multi <= multi + 1;
            if (o_grant != 0 && prev_grant == 0) begin
                go_q.push_back(gidx(o_grant));
                gdur <= 1;
            end else if (o_grant != 0) begin
                gdur <= gdur + 1;
            end else if (prev_grant != 0) begin
                gd_q.push_back(gdur);
            end
            prev_grant <= o_grant;
        end
    end

    int m_ptr = 0;
    int fchk  = 0;

    task automatic set_plan(input int k, input int len, input int nv, input int la);
        p_len[k] = len; p_nv[k] = nv; p_la[k] = la;
        for (int j = 0; j < 64; j++) p_d[k][j] = 8'($urandom);
    endtask

    task automatic rand_plan(input int k);
        int len, mode;
        len  = int'($urandom_range(1, 12));
        mode = int'($urandom_range(0, 9));
        if (mode == 9)                  set_plan(k, len, 0, -1);
        else if (mode >= 6 && len > 1)  set_plan(k, len, len, int'($urandom_range(0, len - 2)));
        else if (mode >= 4 && len > 1)  set_plan(k, len, int'($urandom_range(1, len - 1)), len - 1);
        else if (mode == 3)             set_plan(k, len, len + 2, -1);
        else                            set_plan(k, len, len, len - 1);
    endtask

    // Number of requester bytes that make it into the frame before padding.
    function automatic int acc_of(input int k);
        if (p_la[k] >= 0 && p_la[k] < p_len[k] - 1 && p_la[k] < p_nv[k]) return p_la[k] + 1;
        return (p_nv[k] < p_len[k]) ? p_nv[k] : p_len[k];
    endfunction

    function automatic int err_of(input int k);
        return (acc_of(k) == p_len[k] && p_la[k] == p_len[k] - 1) ? 0 : 1;
    endfunction

    task automatic drive(input int k);
        int w = 0;
        i_req_len[16*k +: 16] = 16'(p_len[k]);
        i_req[k] = 1'b1;
        while (!o_grant[k] && w < 600) begin
            @(posedge clk); #1; w++;
        end
        i_req[k] = 1'b0;
        chk($sformatf("grant_wait_ch%0d", k), 32'(w < 600), 32'd1);
        if (w >= 600) return;
        for (int j = 0; j < 200; j++) begin
            if (j < p_nv[k]) begin
                i_valid[k] = 1'b1;
                i_data[8*k +: 8] = p_d[k][j];
                i_last[k] = (j == p_la[k]);
            end else begin
                i_valid[k] = 1'b0;
                i_last[k] = 1'b0;
            end
            @(posedge clk); #1;
            if (!o_grant[k]) break;
        end
        i_valid[k] = 1'b0;
        i_last[k] = 1'b0;
        i_data[8*k +: 8] = '0;
    endtask

    task automatic check_frame(input int k);
        int w = 0, n, acc;
        logic [7:0] eb, ob;
        while (frames_done <= fchk && w < 2000) begin
            @(negedge clk); w++;
        end
        chk($sformatf("frame_arrive_ch%0d", k), 32'(frames_done > fchk), 32'd1);
        if (frames_done <= fchk) return;
        fchk++;
        acc = acc_of(k);
`ifdef UDP_ARB_CHID_EN
        n = p_len[k] + 1;
`else
        n = p_len[k];
`endif
        for (int j = 0; j < n; j++) begin
            int pi;
            chk($sformatf("ch%0d_byte%0d_present", k, j), 32'(ob_q.size() > 0), 32'd1);
            if (ob_q.size() == 0) break;
`ifdef UDP_ARB_CHID_EN
            pi = j - 1;
            eb = (j == 0) ? 8'(k) : ((pi < acc) ? p_d[k][pi] : 8'h00);
`else
            pi = j;
            eb = (pi < acc) ? p_d[k][pi] : 8'h00;
`endif
            ob = ob_q.pop_front();
            chk($sformatf("ch%0d_byte%0d_data", k, j), 32'(ob), 32'(eb));
            chk($sformatf("ch%0d_byte%0d_last", k, j), 32'(ol_q.pop_front()), 32'(j == n - 1));
            chk($sformatf("ch%0d_byte%0d_len", k, j), 32'(olen_q.pop_front()), 32'(n));
        end
    endtask

    // One arbitration round: all channels in use_m request in the same cycle.
    task automatic txn(input bit [NCH-1:0] use_m, input bit ready_glitch);
        int e0, t0, exp_err, exp_to, p, dur;
        bit [NCH-1:0] pend;
        int ord[$];
        e0 = errs; t0 = tos; exp_err = 0; exp_to = 0;
        pend = use_m; p = m_ptr;
        while (pend != 0) begin
            for (int i = 0; i < NCH; i++) begin
                int c;
                c = (p + i) % NCH;
                if (pend[c]) begin
                    ord.push_back(c);
                    pend[c] = 1'b0;
                    p = (c + 1) % NCH;
                    break;
                end
            end
        end
        fork
            begin if (use_m[0]) drive(0); end
            begin if (use_m[1]) drive(1); end
            begin if (use_m[2]) drive(2); end
            begin
                if (ready_glitch) begin
                    repeat (4) @(posedge clk); #2 i_send_ready = 1'b0;
                    repeat (4) @(posedge clk); #2 i_send_ready = 1'b1;
                end
            end
        join
        repeat (2) @(negedge clk);
        foreach (ord[i]) begin
            int k;
            k = ord[i];
            chk($sformatf("grant_order_%0d", i), 32'(go_q.size() > 0 ? go_q.pop_front() : -1), 32'(k));
            dur = (gd_q.size() > 0) ? gd_q.pop_front() : -1;
            if (p_nv[k] == 0) begin
                chk($sformatf("timeout_grant_cycles_ch%0d", k), 32'(dur), 32'(START_TO));
                exp_to++;
            end else begin
                check_frame(k);
                exp_err += err_of(k);
            end
        end
        m_ptr = p;
        chk("len_err_pulses", 32'(errs - e0), 32'(exp_err));
        chk("timeout_pulses", 32'(tos - t0), 32'(exp_to));
        while (idle_q.size() > 0) chk("inter_packet_gap", 32'(idle_q.pop_front() >= IFG), 32'd1);
    endtask

    initial begin
        int w;
        logic [7:0] t1 [8];
        t1 = '{8'd100, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0};

        // Reset state
        #3 rst_n = 1'b0;
        #10;
        chk("rst_valid", 32'(o_send_valid), 0);
        chk("rst_grant", 32'(o_grant), 0);
        chk("rst_len", 32'(o_send_len), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_len_err", 32'(o_len_err), 0);
        chk("rst_timeout", 32'(o_timeout), 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Stack not ready: nothing is granted
        i_send_ready = 1'b0;
        i_req_len[15:0] = 16'd3;
        i_req[0] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("not_ready_grant", 32'(o_grant), 0);
        chk("not_ready_busy", 32'(o_busy), 0);
        i_req[0] = 1'b0;
        i_send_ready = 1'b1;
        @(posedge clk); #1;

        // 1: ch0 len 8 directed bytes, ready toggles mid-packet
        set_plan(0, 8, 8, 7);
        for (int j = 0; j < 8; j++) p_d[0][j] = t1[j];
        txn(3'b001, 1'b1);

        // 2: simultaneous ch0/ch1 pairs
        set_plan(0, 4, 4, 3); set_plan(1, 4, 4, 3);
        txn(3'b011, 1'b0);
        set_plan(0, 4, 4, 3); set_plan(1, 4, 4, 3);
        txn(3'b011, 1'b0);

        // 3: ch1 early last
        set_plan(1, 6, 6, 2);
        txn(3'b010, 1'b0);

        // 4: ch0 never starts, ch1 pending
        set_plan(0, 5, 0, -1); set_plan(1, 3, 3, 2);
        txn(3'b011, 1'b0);

        // Zero-length request is never granted; len 1; len reached without i_last
        i_req_len[47:32] = '0;
        i_req[2] = 1'b1;
        set_plan(0, 3, 3, 2);
        txn(3'b001, 1'b0);
        repeat (30) @(negedge clk);
        chk("len0_never_granted", 32'(go_q.size()), 0);
        chk("len0_idle_busy", 32'(o_busy), 0);
        i_req[2] = 1'b0;
        set_plan(1, 1, 1, 0);
        txn(3'b010, 1'b0);
        set_plan(0, 5, 7, -1);
        txn(3'b001, 1'b0);

        // 5: reset in the middle of a packet
        i_req_len[15:0] = 16'd8;
        i_req[0] = 1'b1;
        w = 0;
        while (!o_grant[0] && w < 600) begin
            @(posedge clk); #1; w++;
        end
        i_req[0] = 1'b0;
        chk("rst_test_grant_wait", 32'(w < 600), 1);
        for (int j = 0; j < 3; j++) begin
            i_valid[0] = 1'b1;
            i_data[7:0] = 8'($urandom);
            @(posedge clk); #1;
        end
        chk("mid_packet_valid", 32'(o_send_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(o_send_valid), 0);
        chk("async_rst_grant", 32'(o_grant), 0);
        chk("async_rst_len", 32'(o_send_len), 0);
        chk("async_rst_busy", 32'(o_busy), 0);
        i_valid = '0; i_last = '0; i_data = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        ob_q.delete(); ol_q.delete(); olen_q.delete();
        go_q.delete(); gd_q.delete(); idle_q.delete();
        m_ptr = 0;
        set_plan(0, 2, 2, 1);
        txn(3'b001, 1'b0);

        // Randomized rounds
        for (int r = 0; r < 25; r++) begin
            bit [NCH-1:0] u;
            u = NCH'($urandom_range(1, 7));
            for (int k = 0; k < NCH; k++) if (u[k]) rand_plan(k);
            txn(u, 1'b0);
        end

        repeat (20) @(negedge clk);
        chk("no_hole_inside_frame", 32'(gaps), 0);
        chk("grant_onehot", 32'(multi), 0);
        chk("len_zero_when_idle", 32'(len_nz), 0);
        chk("no_stray_bytes", 32'(ob_q.size()), 0);
        chk("no_stray_grants", 32'(go_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
